// File: rtl/alu4_arbiter_if.sv
// Request/operand and result/flag bundle between two ALU requesters and the shared-ALU arbiter.
interface alu4_arbiter_if #(
   parameter int unsigned CNT_WIDTH = 8
);
   logic                 req0;
   logic [3:0]           a0;
   logic [3:0]           b0;
   logic [2:0]           op0;
   logic                 req1;
   logic [3:0]           a1;
   logic [3:0]           b1;
   logic [2:0]           op1;
   logic                 done0;
   logic                 done1;
   logic                 owner;
   logic                 busy;
   logic [3:0]           result;
   logic                 c;
   logic                 n;
   logic                 z;
   logic                 v;
   logic [CNT_WIDTH-1:0] op_cnt;

   modport master (
      output req0, a0, b0, op0, req1, a1, b1, op1,
      input  done0, done1, owner, busy, result, c, n, z, v, op_cnt
   );

   modport slave (
      input  req0, a0, b0, op0, req1, a1, b1, op1,
      output done0, done1, owner, busy, result, c, n, z, v, op_cnt
   );
endinterface

// File: rtl/alu4_arbiter.sv
// Round-robin arbiter time-sharing one 4-bit ALU between two requesters.

// Combinational 4-bit ALU; carry/overflow only meaningful for add/subtract.
module alu4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] op,
   output logic [3:0] res_c,
   output logic       c_c,
   output logic       n_c,
   output logic       z_c,
   output logic       v_c
);
   logic [3:0] b_eff_c;
   logic [4:0] sum_c;

   // Opcode decode; subtract reuses the adder as a + ~b + 1.
   always_comb begin
      res_c   = 4'd0;
      c_c     = 1'b0;
      v_c     = 1'b0;
      b_eff_c = op[0] ? ~b : b;
      sum_c   = 5'(a) + 5'(b_eff_c) + 5'(op[0]);
      case (op)
         3'b000:  res_c = ~a;
         3'b001:  res_c = ~b;
         3'b010:  res_c = a & b;
         3'b011:  res_c = a | b;
         3'b100:  res_c = a ^ b;
         3'b101:  res_c = ~(a ^ b);
         default: begin
            res_c = sum_c[3:0];
            c_c   = sum_c[4];
            v_c   = (a[3] == b_eff_c[3]) && (sum_c[3] != a[3]);
         end
      endcase
      n_c = res_c[3];
      z_c = (res_c == 4'd0);
   end
endmodule

module alu4_arbiter #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   alu4_arbiter_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state_q,  state_d;
   logic                 owner_q,  owner_d;
   logic                 last_q,   last_d;
   logic [3:0]           a_q,      a_d;
   logic [3:0]           b_q,      b_d;
   logic [2:0]           op_q,     op_d;
   logic [3:0]           result_q, result_d;
   logic                 c_q,      c_d;
   logic                 n_q,      n_d;
   logic                 z_q,      z_d;
   logic                 v_q,      v_d;
   logic                 done0_q,  done0_d;
   logic                 done1_q,  done1_d;
   logic                 busy_q,   busy_d;
   logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;

   logic                 grant1_c;
   logic [3:0]           alu_res_c;
   logic                 alu_c_c;
   logic                 alu_n_c;
   logic                 alu_z_c;
   logic                 alu_v_c;

   alu4 u_alu (
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
      .res_c (alu_res_c),
      .c_c   (alu_c_c),
      .n_c   (alu_n_c),
      .z_c   (alu_z_c),
      .v_c   (alu_v_c)
   );

   // Next-state, arbitration and result capture.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      c_d      = c_q;
      n_d      = n_q;
      z_d      = z_q;
      v_d      = v_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      busy_d   = busy_q;
      op_cnt_d = op_cnt_q;
      // On a tie the requester that was not served last wins.
      grant1_c = bus.req1 & (~bus.req0 | ~last_q);
      case (state_q)
         ST_IDLE: begin
            if (bus.req0 | bus.req1) begin
               owner_d = grant1_c;
               a_d     = grant1_c ? bus.a1  : bus.a0;
               b_d     = grant1_c ? bus.b1  : bus.b0;
               op_d    = grant1_c ? bus.op1 : bus.op0;
               busy_d  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d = alu_res_c;
            c_d      = alu_c_c;
            n_d      = alu_n_c;
            z_d      = alu_z_c;
            v_d      = alu_v_c;
            done0_d  = ~owner_q;
            done1_d  = owner_q;
            op_cnt_d = op_cnt_q + CNT_WIDTH'(1);
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            last_d  = owner_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         op_q     <= 3'd0;
         result_q <= 4'd0;
         c_q      <= 1'b0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         v_q      <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         op_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         c_q      <= c_d;
         n_q      <= n_d;
         z_q      <= z_d;
         v_q      <= v_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         op_cnt_q <= op_cnt_d;
      end
   end

   assign bus.done0  = done0_q;
   assign bus.done1  = done1_q;
   assign bus.owner  = owner_q;
   assign bus.busy   = busy_q;
   assign bus.result = result_q;
   assign bus.c      = c_q;
   assign bus.n      = n_q;
   assign bus.z      = z_q;
   assign bus.v      = v_q;
   assign bus.op_cnt = op_cnt_q;
endmodule
